// File: rtl/data_mem_ls_pkg.sv
// Shared encodings for the load/store data memory: access sizes, FSM
// states, and the alignment rule used to flag faulting accesses.
package data_mem_ls_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_RESP = 2'b10
    } state_e;

    // Wide enough for WAIT_STATES up to 7.
    localparam int CNT_W = 3;

    // An access faults when it is misaligned for its size or the size is illegal.
    function automatic logic misaligned(input size_e size, input logic [1:0] a);
        logic f;
        case (size)
            SZ_BYTE: f = 1'b0;
            SZ_HALF: f = a[0];
            SZ_WORD: f = (a != 2'b00);
            default: f = 1'b1;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/data_mem_ls_sram_be.sv
// Single-port 32-bit word memory with per-byte write enables.
// Writes land on the rising edge; reads are combinational. Not reset.
module sram_be #(
    parameter int DEPTH = 512,
    parameter int AW    = 9
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [3:0]    be_i,
    input  logic [AW-1:0] addr_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [DEPTH];

    // Byte-lane write; lanes whose enable is low keep their contents.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int i = 0; i < 4; i++) begin
                if (be_i[i]) mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
            end
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/data_mem_ls.sv
// Load/store front end for a byte-addressed data memory: accepts one request,
// waits WAIT_STATES extra cycles, performs the access, and pulses a response.
// Misaligned or illegal-size requests fault without touching memory.
module data_mem_ls
    import data_mem_ls_pkg::*;
#(
    parameter int ADDR_W      = 11,
    parameter int WAIT_STATES = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              rsp_valid,
    output logic [31:0]       rdata,
    output logic              rsp_err
);

    localparam int WA    = ADDR_W - 2;
    localparam int DEPTH = 2 ** WA;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ready_q;
    logic               we_q, uns_q;
    size_e              size_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [31:0]        wdata_q;
    logic [31:0]        rdata_q, rdata_d;
    logic               err_q;

    logic               accept, access, fault;
    logic [3:0]         be;
    logic [31:0]        wlane, mem_rd, shifted, load_val;

    assign accept = req_valid && ready_q;
    assign access = (state_q == ST_WAIT) && (cnt_q == '0);
    assign fault  = misaligned(size_q, addr_q[1:0]);

    // Next-state logic: IDLE -> WAIT (count down) -> RESP -> IDLE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: if (accept) begin
                state_d = ST_WAIT;
                cnt_d   = CNT_W'(WAIT_STATES);
            end
            ST_WAIT: begin
                if (cnt_q == '0) state_d = ST_RESP;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Store steering: replicate the right-aligned data across lanes, enable only the addressed ones.
    always_comb begin
        be    = 4'b0000;
        wlane = wdata_q;
        case (size_q)
            SZ_BYTE: begin
                be    = 4'b0001 << addr_q[1:0];
                wlane = {4{wdata_q[7:0]}};
            end
            SZ_HALF: begin
                be    = addr_q[1] ? 4'b1100 : 4'b0011;
                wlane = {2{wdata_q[15:0]}};
            end
            SZ_WORD: be = 4'b1111;
            default: be = 4'b0000;
        endcase
    end

    // Load path: right-align the addressed lanes and extend; stores and faults return zero.
    always_comb begin
        shifted  = mem_rd >> {addr_q[1:0], 3'b000};
        load_val = '0;
        case (size_q)
            SZ_BYTE: load_val = uns_q ? {24'b0, shifted[7:0]}  : {{24{shifted[7]}},  shifted[7:0]};
            SZ_HALF: load_val = uns_q ? {16'b0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
            SZ_WORD: load_val = mem_rd;
            default: load_val = '0;
        endcase
        rdata_d = (we_q || fault) ? 32'b0 : load_val;
    end

    // State, request capture, and response registers; ready tracks the next state so it
    // rises on the first edge after reset release and falls on the accept edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            size_q  <= SZ_BYTE;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= (state_d == ST_IDLE);
            if (accept) begin
                we_q    <= req_we;
                uns_q   <= req_unsigned;
                size_q  <= size_e'(req_size);
                addr_q  <= addr;
                wdata_q <= wdata;
            end
            if (access) begin
                rdata_q <= rdata_d;
                err_q   <= fault;
            end
        end
    end

    sram_be #(
        .DEPTH (DEPTH),
        .AW    (WA)
    ) u_sram (
        .clk_i   (clk),
        .we_i    (access && we_q && !fault),
        .be_i    (be),
        .addr_i  (addr_q[ADDR_W-1:2]),
        .wdata_i (wlane),
        .rdata_o (mem_rd)
    );

    assign req_ready = ready_q;
    assign rsp_valid = (state_q == ST_RESP);
    assign rdata     = rdata_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_data_mem_ls.sv
// Bench for data_mem_ls: two instances (WAIT_STATES 0 and 3) driven from a
// vector table, plus hand sequences for reset, back-to-back timing and
// reset during a pending store.
module tb_data_mem_ls;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [1:0]       req_valid, req_ready, req_we, req_unsigned, rsp_valid, rsp_err;
    logic [1:0][1:0]  req_size;
    logic [1:0][10:0] addr;
    logic [1:0][31:0] wdata, rdata;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    data_mem_ls #(.ADDR_W(11), .WAIT_STATES(0)) u_ws0 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
        .req_size(req_size[0]), .req_unsigned(req_unsigned[0]), .addr(addr[0]),
        .wdata(wdata[0]), .rsp_valid(rsp_valid[0]), .rdata(rdata[0]), .rsp_err(rsp_err[0])
    );

    data_mem_ls #(.ADDR_W(11), .WAIT_STATES(3)) u_ws3 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
        .req_size(req_size[1]), .req_unsigned(req_unsigned[1]), .addr(addr[1]),
        .wdata(wdata[1]), .rsp_valid(rsp_valid[1]), .rdata(rdata[1]), .rsp_err(rsp_err[1])
    );

    typedef struct {
        int          d;
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [10:0] a;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t vt[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // One request on instance d; returns response data/error and cycles from accept to pulse.
    task automatic txn(input int d, input logic we, input logic [1:0] sz, input logic uns,
                       input logic [10:0] a, input logic [31:0] wd,
                       output logic [31:0] rd, output logic er, output int lat);
        int n;
        @(negedge clk);
        req_valid[d] = 1'b1; req_we[d] = we; req_size[d] = sz;
        req_unsigned[d] = uns; addr[d] = a; wdata[d] = wd;
        n = 0;
        while (!req_ready[d] && n < 20) begin
            @(negedge clk);
            n++;
        end
        rd = 'x; er = 1'bx; lat = -1;
        if (!req_ready[d]) begin
            req_valid[d] = 1'b0;
            return;
        end
        @(posedge clk); #1;
        // Scramble the inputs after accept: the DUT must use its captured copy.
        req_valid[d] = 1'b0; req_we[d] = ~we; req_size[d] = ~sz;
        req_unsigned[d] = ~uns; addr[d] = ~a; wdata[d] = ~wd;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (rsp_valid[d]) begin
                lat = i; rd = rdata[d]; er = rsp_err[d];
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat, a0, a1, a2, seen;
        logic        r[24];
        logic        v[24];

        // Directed vectors: {inst, we, size, uns, addr, wdata, exp rdata, exp err}
        vt.push_back('{0, 1'b1, 2'b10, 1'b0, 11'h004, 32'hDEADBEEF, 32'h0,        1'b0});
        vt.push_back('{0, 1'b0, 2'b10, 1'b0, 11'h004, 32'h0,        32'hDEADBEEF, 1'b0});
        vt.push_back('{0, 1'b1, 2'b00, 1'b0, 11'h006, 32'h123456A5, 32'h0,        1'b0});
        vt.push_back('{0, 1'b0, 2'b10, 1'b0, 11'h004, 32'h0,        32'hDEA5BEEF, 1'b0});
        vt.push_back('{0, 1'b0, 2'b00, 1'b0, 11'h006, 32'h0,        32'hFFFFFFA5, 1'b0});
        vt.push_back('{0, 1'b0, 2'b00, 1'b1, 11'h006, 32'h0,        32'h000000A5, 1'b0});
        vt.push_back('{0, 1'b0, 2'b01, 1'b0, 11'h003, 32'h0,        32'h0,        1'b1});
        vt.push_back('{0, 1'b1, 2'b10, 1'b0, 11'h005, 32'h11111111, 32'h0,        1'b1});
        vt.push_back('{0, 1'b0, 2'b10, 1'b0, 11'h004, 32'h0,        32'hDEA5BEEF, 1'b0});
        vt.push_back('{0, 1'b0, 2'b00, 1'b0, 11'h007, 32'h0,        32'hFFFFFFDE, 1'b0});
        vt.push_back('{0, 1'b0, 2'b00, 1'b1, 11'h004, 32'h0,        32'h000000EF, 1'b0});
        vt.push_back('{0, 1'b1, 2'b10, 1'b0, 11'h008, 32'h00000000, 32'h0,        1'b0});
        vt.push_back('{0, 1'b1, 2'b01, 1'b0, 11'h00A, 32'hFFFFCAFE, 32'h0,        1'b0});
        vt.push_back('{0, 1'b0, 2'b10, 1'b0, 11'h008, 32'h0,        32'hCAFE0000, 1'b0});
        vt.push_back('{0, 1'b0, 2'b01, 1'b0, 11'h00A, 32'h0,        32'hFFFFCAFE, 1'b0});
        vt.push_back('{0, 1'b0, 2'b01, 1'b1, 11'h00A, 32'h0,        32'h0000CAFE, 1'b0});
        vt.push_back('{0, 1'b0, 2'b11, 1'b0, 11'h000, 32'h0,        32'h0,        1'b1});
        vt.push_back('{0, 1'b1, 2'b10, 1'b0, 11'h7FC, 32'hA1B2C3D4, 32'h0,        1'b0});
        vt.push_back('{0, 1'b0, 2'b01, 1'b0, 11'h7FE, 32'h0,        32'hFFFFA1B2, 1'b0});
        vt.push_back('{1, 1'b1, 2'b10, 1'b0, 11'h008, 32'h55AA0FF0, 32'h0,        1'b0});
        vt.push_back('{1, 1'b0, 2'b10, 1'b0, 11'h008, 32'h0,        32'h55AA0FF0, 1'b0});
        vt.push_back('{1, 1'b0, 2'b01, 1'b1, 11'h00A, 32'h0,        32'h000055AA, 1'b0});
        vt.push_back('{1, 1'b0, 2'b00, 1'b0, 11'h009, 32'h0,        32'h0000000F, 1'b0});
        vt.push_back('{1, 1'b0, 2'b10, 1'b0, 11'h00A, 32'h0,        32'h0,        1'b1});

        req_valid = '0; req_we = '0; req_size = '0; req_unsigned = '0; addr = '0; wdata = '0;

        // Reset state: outputs forced low immediately, ready rises on first edge after release.
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("rst_ready%0d", d), 32'(req_ready[d]), 32'h0);
            chk($sformatf("rst_rspv%0d", d),  32'(rsp_valid[d]), 32'h0);
            chk($sformatf("rst_rdata%0d", d), rdata[d],          32'h0);
            chk($sformatf("rst_err%0d", d),   32'(rsp_err[d]),   32'h0);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        for (int d = 0; d < 2; d++)
            chk($sformatf("post_rst_ready%0d", d), 32'(req_ready[d]), 32'h1);

        // Table: response data, error, latency, single-cycle pulse and held data.
        foreach (vt[i]) begin
            txn(vt[i].d, vt[i].we, vt[i].size, vt[i].uns, vt[i].a, vt[i].wd, rd, er, lat);
            chk($sformatf("v%0d_rdata", i), rd, vt[i].exp_rd);
            chk($sformatf("v%0d_err", i), 32'(er), 32'(vt[i].exp_err));
            chk($sformatf("v%0d_lat", i), 32'(lat), (vt[i].d == 0) ? 32'd1 : 32'd4);
            @(posedge clk); #1;
            chk($sformatf("v%0d_pulse_end", i), 32'(rsp_valid[vt[i].d]), 32'h0);
            chk($sformatf("v%0d_hold", i), rdata[vt[i].d], vt[i].exp_rd);
        end

        // Back-to-back loads on the 3-wait-state instance with req_valid held high.
        @(negedge clk);
        req_valid[1] = 1'b1; req_we[1] = 1'b0; req_size[1] = 2'b10;
        req_unsigned[1] = 1'b0; addr[1] = 11'h008; wdata[1] = '0;
        for (int n = 0; n < 24; n++) begin
            if (n > 0) @(negedge clk);
            r[n] = req_ready[1];
            v[n] = rsp_valid[1];
        end
        req_valid[1] = 1'b0;
        a0 = -1; a1 = -1; a2 = -1;
        for (int n = 0; n < 24; n++) begin
            if (r[n]) begin
                if (a0 < 0)      a0 = n;
                else if (a1 < 0) a1 = n;
                else if (a2 < 0) a2 = n;
            end
        end
        chk("b2b_first_accept", 32'(a0), 32'd0);
        chk("b2b_ready_low1", 32'(a1 - a0 - 1), 32'd5);
        chk("b2b_ready_low2", 32'(a2 - a1 - 1), 32'd5);
        // Accept at edge a0; pulse follows edge a0+4, so it is seen at negedge a0+5 only.
        chk("b2b_rsp_early", 32'(v[4]), 32'h0);
        chk("b2b_rsp_pulse", 32'(v[5]), 32'h1);
        chk("b2b_rsp_late",  32'(v[6]), 32'h0);
        chk("b2b_rdata", rdata[1], 32'h55AA0FF0);
        repeat (10) @(negedge clk);

        // Reset while a store waits: nothing committed, no response.
        req_valid[1] = 1'b1; req_we[1] = 1'b1; req_size[1] = 2'b10;
        addr[1] = 11'h008; wdata[1] = 32'h12345678;
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("wrst_ready", 32'(req_ready[1]), 32'h0);
        chk("wrst_rspv",  32'(rsp_valid[1]), 32'h0);
        chk("wrst_rdata", rdata[1], 32'h0);
        chk("wrst_rdata0", rdata[0], 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (rsp_valid[1]) seen++;
        end
        chk("wrst_no_rsp", 32'(seen), 32'h0);
        txn(1, 1'b0, 2'b10, 1'b0, 11'h008, 32'h0, rd, er, lat);
        chk("wrst_mem_kept", rd, 32'h55AA0FF0);
        chk("wrst_err", 32'(er), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
